// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the Ibex memory arbiter.
package ibex_pkg;
    typedef enum logic {ArbInstr = 1'b0, ArbData = 1'b1} mem_arb_id_e;
endpackage

// File: rtl/ibex_mem_arbiter_id_fifo.sv
// ibex_mem_arbiter_id_fifo: in-order FIFO of requester IDs for granted-but-unanswered transactions.
module ibex_mem_arbiter_id_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  mem_arb_id_e id_i,
    output logic        full_o,
    output logic        empty_o,
    output mem_arb_id_e head_o
);
    localparam int unsigned PW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mem_arb_id_e   ids_q [Depth];

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_d    = push_i ? inc(wr_q) : wr_q;
        rd_d    = pop_i ? inc(rd_q) : rd_q;
        cnt_d   = cnt_q + CW'(push_i) - CW'(pop_i);
        full_o  = cnt_q == CW'(Depth);
        empty_o = cnt_q == '0;
        head_o  = ids_q[rd_q];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) ids_q[wr_q] <= id_i;
    end
endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: shares one memory port between the instr and data ports.
// Define IBEX_MEM_ARB_RR_EN for round-robin conflict resolution; default is data-over-instr priority.
module ibex_mem_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        spurious_rvalid_o
);
    logic        full, empty, push, pop, lock_q, lock_d;
    mem_arb_id_e head, sel, win, lock_sel_q;

`ifdef IBEX_MEM_ARB_RR_EN
    mem_arb_id_e last_q;
    assign win = (last_q == ArbData) ? ArbInstr : ArbData;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= ArbInstr;
        else if (push) last_q <= sel;
    end
`else
    assign win = ArbData;
`endif

    always_comb begin
        mem_req_o         = (instr_req_i | data_req_i) & ~full;
        sel               = lock_q ? lock_sel_q : (instr_req_i & data_req_i) ? win :
                            data_req_i ? ArbData : ArbInstr;
        push              = mem_req_o & mem_gnt_i & ~rst_i;
        pop               = mem_rvalid_i & ~empty & ~rst_i;
        lock_d            = mem_req_o & ~mem_gnt_i;
        mem_we_o          = (sel == ArbData) ? data_we_i : 1'b0;
        mem_be_o          = (sel == ArbData) ? data_be_i : 4'hF;
        mem_addr_o        = (sel == ArbData) ? data_addr_i : instr_addr_i;
        mem_wdata_o       = (sel == ArbData) ? data_wdata_i : 32'h0;
        instr_gnt_o       = push & (sel == ArbInstr);
        data_gnt_o        = push & (sel == ArbData);
        instr_rvalid_o    = pop & (head == ArbInstr);
        data_rvalid_o     = pop & (head == ArbData);
        instr_err_o       = instr_rvalid_o & mem_err_i;
        data_err_o        = data_rvalid_o & mem_err_i;
        instr_rdata_o     = mem_rdata_i;
        data_rdata_o      = mem_rdata_i;
        spurious_rvalid_o = mem_rvalid_i & empty & ~rst_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_sel_q <= ArbInstr;
        end else begin
            lock_q     <= lock_d;
            lock_sel_q <= sel;
        end
    end

    ibex_mem_arbiter_id_fifo #(.Depth(MaxOutstanding)) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .id_i    (sel),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );
endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb_ibex_mem_arbiter: directed self-checking bench for ibex_mem_arbiter (MaxOutstanding=2).
module tb_ibex_mem_arbiter;
    logic        clk_i = 1'b0, rst_i;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i, spurious_rvalid_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    int          n_chk = 0, n_fail = 0;

    always #5 clk_i = ~clk_i;

    ibex_mem_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .spurious_rvalid_o(spurious_rvalid_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0; data_be_i = 0;
        data_addr_i = 0; data_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
    endtask

    task automatic test_reset;
        idle();
        rst_i = 1; instr_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
        #2;
        n_chk++; if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, spurious_rvalid_o} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 00000",
                {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, spurious_rvalid_o}); end
        tick(); tick();
        idle();
        rst_i = 0;
        tick();
    endtask

    task automatic test_single_read;
        instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
        #2;
        n_chk++; if ({mem_req_o, instr_gnt_o, data_gnt_o} !== 3'b110) begin
            n_fail++; $display("FAIL single_gnt: got %b want 110", {mem_req_o, instr_gnt_o, data_gnt_o}); end
        n_chk++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b0, 4'hF, 32'h100, 32'h0}) begin
            n_fail++; $display("FAIL single_payload: got %h want %h", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                {1'b0, 4'hF, 32'h100, 32'h0}); end
        tick();
        idle();
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        #2;
        n_chk++; if ({instr_rvalid_o, data_rvalid_o, instr_err_o, spurious_rvalid_o} !== 4'b1000) begin
            n_fail++; $display("FAIL single_rvalid: got %b want 1000",
                {instr_rvalid_o, data_rvalid_o, instr_err_o, spurious_rvalid_o}); end
        n_chk++; if (instr_rdata_o !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_rdata: got %h want deadbeef", instr_rdata_o); end
        tick();
        idle();
    endtask

    task automatic test_conflict;
        logic w, prev;
        prev = 0;
        instr_req_i = 1; instr_addr_i = 32'h300; data_req_i = 1; data_addr_i = 32'h200;
        data_we_i = 1; data_be_i = 4'h3; data_wdata_i = 32'h55; mem_gnt_i = 1;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = (k > 0);
`ifdef IBEX_MEM_ARB_RR_EN
            w = (k % 2) == 0;
`else
            w = 1'b1;
`endif
            #2;
            n_chk++; if ({data_gnt_o, instr_gnt_o} !== {w, ~w}) begin
                n_fail++; $display("FAIL conflict_gnt[%0d]: got %b want %b", k, {data_gnt_o, instr_gnt_o}, {w, ~w}); end
            n_chk++; if ({mem_we_o, mem_be_o, mem_addr_o} !== (w ? {1'b1, 4'h3, 32'h200} : {1'b0, 4'hF, 32'h300})) begin
                n_fail++; $display("FAIL conflict_payload[%0d]: got %h sel_data=%b", k, {mem_we_o, mem_be_o, mem_addr_o}, w); end
            if (k > 0) begin
                n_chk++; if ({data_rvalid_o, instr_rvalid_o} !== {prev, ~prev}) begin
                    n_fail++; $display("FAIL conflict_rvalid[%0d]: got %b want %b", k,
                        {data_rvalid_o, instr_rvalid_o}, {prev, ~prev}); end
            end
            prev = w;
            tick();
        end
        idle();
        mem_rvalid_i = 1;
        #2;
        n_chk++; if ({data_rvalid_o, instr_rvalid_o} !== {prev, ~prev}) begin
            n_fail++; $display("FAIL conflict_drain: got %b want %b", {data_rvalid_o, instr_rvalid_o}, {prev, ~prev}); end
        tick();
        idle();
    endtask

    task automatic test_lock;
        instr_req_i = 1; instr_addr_i = 32'h400;
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin data_req_i = 1; data_addr_i = 32'h500; end
            #2;
            n_chk++; if ({mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o} !== {1'b1, 32'h400, 2'b00}) begin
                n_fail++; $display("FAIL lock_hold[%0d]: got %h want %h", c,
                    {mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o}, {1'b1, 32'h400, 2'b00}); end
            tick();
        end
        mem_gnt_i = 1;
        #2;
        n_chk++; if ({mem_addr_o, instr_gnt_o, data_gnt_o} !== {32'h400, 2'b10}) begin
            n_fail++; $display("FAIL lock_grant: got %h want %h", {mem_addr_o, instr_gnt_o, data_gnt_o}, {32'h400, 2'b10}); end
        tick();
        instr_req_i = 0;
        #2;
        n_chk++; if ({mem_addr_o, instr_gnt_o, data_gnt_o} !== {32'h500, 2'b01}) begin
            n_fail++; $display("FAIL lock_after: got %h want %h", {mem_addr_o, instr_gnt_o, data_gnt_o}, {32'h500, 2'b01}); end
        tick();
        idle();
        mem_rvalid_i = 1;
        #2;
        n_chk++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
            n_fail++; $display("FAIL lock_resp1: got %b want 10", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        #1;
        n_chk++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
            n_fail++; $display("FAIL lock_resp2: got %b want 01", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        idle();
    endtask

    task automatic test_outstanding;
        data_req_i = 1; data_addr_i = 32'h600; mem_gnt_i = 1;
        tick(); tick();
        mem_rvalid_i = 1;
        #2;
        n_chk++; if ({mem_req_o, data_gnt_o, data_rvalid_o} !== 3'b001) begin
            n_fail++; $display("FAIL full_block: got %b want 001", {mem_req_o, data_gnt_o, data_rvalid_o}); end
        tick();
        mem_rvalid_i = 0; mem_gnt_i = 0;
        #2;
        n_chk++; if (mem_req_o !== 1'b1) begin
            n_fail++; $display("FAIL full_release: got %b want 1", mem_req_o); end
        tick();
        idle();
        mem_rvalid_i = 1;
        #2;
        n_chk++; if (data_rvalid_o !== 1'b1) begin
            n_fail++; $display("FAIL full_drain: got %b want 1", data_rvalid_o); end
        tick();
        idle();
    endtask

    task automatic test_err;
        data_req_i = 1; mem_gnt_i = 1;
        tick();
        data_req_i = 0; instr_req_i = 1;
        tick();
        idle();
        mem_rvalid_i = 1;
        #2;
        n_chk++; if ({data_rvalid_o, data_err_o, instr_rvalid_o} !== 3'b100) begin
            n_fail++; $display("FAIL err_first: got %b want 100", {data_rvalid_o, data_err_o, instr_rvalid_o}); end
        tick();
        mem_err_i = 1;
        #2;
        n_chk++; if ({instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o} !== 4'b1100) begin
            n_fail++; $display("FAIL err_second: got %b want 1100", {instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o}); end
        tick();
        idle();
    endtask

    task automatic test_spurious;
        mem_rvalid_i = 1;
        #2;
        n_chk++; if ({spurious_rvalid_o, instr_rvalid_o, data_rvalid_o} !== 3'b100) begin
            n_fail++; $display("FAIL spur_empty: got %b want 100", {spurious_rvalid_o, instr_rvalid_o, data_rvalid_o}); end
        tick();
        mem_rvalid_i = 0;
        #2;
        n_chk++; if (spurious_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL spur_clear: got %b want 0", spurious_rvalid_o); end
        instr_req_i = 1; mem_gnt_i = 1;
        tick();
        idle();
        mem_rvalid_i = 1;
        rst_i = 1;
        #1;
        n_chk++; if ({spurious_rvalid_o, instr_rvalid_o, data_rvalid_o} !== 3'b000) begin
            n_fail++; $display("FAIL spur_in_reset: got %b want 000", {spurious_rvalid_o, instr_rvalid_o, data_rvalid_o}); end
        tick();
        rst_i = 0;
        #2;
        n_chk++; if ({spurious_rvalid_o, instr_rvalid_o, data_rvalid_o} !== 3'b100) begin
            n_fail++; $display("FAIL spur_after_reset: got %b want 100", {spurious_rvalid_o, instr_rvalid_o, data_rvalid_o}); end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_conflict();
        test_lock();
        test_outstanding();
        test_err();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ibex_mem_arbiter.md
IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 Parameter MaxOutstanding, default 2, SHALL set the number of granted-but-unanswered transactions (range 1..8).
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1 each  core instruction-port handshake.
REQ-005 instr_addr_i  input  32  instruction address.
REQ-006 instr_rdata_o / instr_err_o  output  32 / 1  instruction response data and error.
REQ-007 data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1 each  core data-port handshake.
REQ-008 data_we_i / data_be_i  input  1 / 4  data write enable and byte enables.
REQ-009 data_addr_i / data_wdata_i  input  32 / 32  data address and write data.
REQ-010 data_rdata_o / data_err_o  output  32 / 1  data response data and error.
REQ-011 mem_req_o / mem_gnt_i / mem_rvalid_i  out/in/in  1 each  shared memory-port handshake.
REQ-012 mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  output  1/4/32/32  shared request payload.
REQ-013 mem_rdata_i / mem_err_i  input  32 / 1  shared response.
REQ-014 spurious_rvalid_o  output  1  one-cycle pulse on mem_rvalid_i with no outstanding transaction.

Function
REQ-015 mem_req_o SHALL equal (instr_req_i | data_req_i) & (count < MaxOutstanding); count is the registered outstanding count, with no bypass of same-cycle pops.
REQ-016 Selected requester SHALL drive mem_we/be/addr/wdata; instr selection SHALL drive mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-017 Lock: while mem_req_o=1 and mem_gnt_i=0, the selection SHALL be registered and held until the grant, even if the other requester rises.
REQ-018 Conflict (both requests, not locked) SHALL be resolved per REQ-027/028.
REQ-019 Grant SHALL be forwarded combinationally only to the selected requester: x_gnt_o = mem_gnt_i & mem_req_o & sel==x.
REQ-020 On each grant handshake the requester ID SHALL be pushed into an in-order ID FIFO; count increments.
REQ-021 On mem_rvalid_i with count>0 the head ID SHALL route rvalid/err to that requester in the same cycle and pop; rdata SHALL pass mem_rdata_i to both ports unconditionally.
REQ-022 Simultaneous grant and rvalid SHALL push and pop in one cycle; count unchanged; full-at-start-of-cycle still blocks the grant.
REQ-023 mem_rvalid_i with count=0 SHALL produce no core rvalid, leave state unchanged, and pulse spurious_rvalid_o.
REQ-024 FIFO pointers SHALL wrap modulo MaxOutstanding; count width SHALL be $clog2(MaxOutstanding+1).

Reset
REQ-025 On rst_i: count=0, FIFO pointers=0, lock=0, last-granted=instr; all rvalid/gnt outputs and spurious_rvalid_o=0 while reset is asserted.
REQ-026 Reset mid-transaction SHALL discard outstanding IDs; later responses SHALL be treated per REQ-023.

Configuration
REQ-027 With IBEX_MEM_ARB_RR_EN defined: round-robin; on conflict, grant the requester not in last-granted, which updates on each grant handshake.
REQ-028 Without IBEX_MEM_ARB_RR_EN: fixed priority, data over instr; last-granted register SHALL be absent.

Structure
REQ-029 ibex_pkg SHALL hold typedef mem_arb_id_e {ArbInstr=1'b0, ArbData=1'b1}.
REQ-030 The ID FIFO SHALL be sub-module ibex_mem_arbiter_id_fifo (parameter Depth, push/pop/full/empty/head).

Verification
REQ-031 Instr-only read addr 0x100, gnt same cycle, rvalid next with rdata 0xDEADBEEF -> instr_gnt_o then instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF, data_rvalid_o=0.
REQ-032 Both request, gnt immediate: RR build -> data, instr, data...; fixed build -> data every cycle while data_req_i=1.
REQ-033 Instr request, gnt held low 3 cycles, data rises in cycle 2 -> mem_addr_o stays instr addr until gnt; data granted afterward.
REQ-034 MaxOutstanding=2, two grants with no rvalid -> mem_req_o=0 in cycle 3; rvalid in cycle 3 -> mem_req_o=1 in cycle 4.
REQ-035 Grant data then instr, two rvalids, second with mem_err_i=1 -> data_rvalid_o first, then instr_rvalid_o with instr_err_o=1.
REQ-036 mem_rvalid_i with count=0, then rst_i pulsed with 1 outstanding -> spurious_rvalid_o pulses in both cases; no core rvalid.
